ps2_letter_input: RTL and testbench
===================================

# ps2_letter_input

Upstream input stage for the falling-letter columns. Receives PS/2 keyboard frames (scan code set 2) from the DE0 PS/2 pins, tracks make/break codes, and drives `user_input` with the ASCII code of the letter key currently held (0x00 when none). Every Column instance compares this byte against its own `letter`. `key_strobe` marks each new letter press.

## Interface
- `TIMEOUT_CYCLES`, default 100000: `clock` cycles without a PS/2 falling edge mid-frame before the frame is aborted (2 ms at 50 MHz).
- `clock`  input  1  system clock, 50 MHz
- `reset_signal`  input  1  synchronous, active-high reset
- `ps2_clk`  input  1  raw PS/2 clock pin, asynchronous, idles high
- `ps2_data`  input  1  raw PS/2 data pin, asynchronous, idles high
- `user_input`  output  8  ASCII 'A'–'Z' (0x41–0x5A) of the held letter key, 0x00 if none
- `key_strobe`  output  1  one-cycle pulse when `user_input` takes a new nonzero value
- `frame_error`  output  1  one-cycle pulse on start, parity, stop or timeout error

## Operation
- Synchronizer: `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer with reset value 1. A falling edge is sync'd clk 1→0 between consecutive cycles. Data is sampled in the edge cycle.
- Frame FSM: IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: on an edge with data=0 go to DATA. On an edge with data=1, stay in IDLE with no error.
  - DATA: shift in 8 bits LSB first. Use a 3-bit counter and go to PARITY after bit 7.
  - PARITY: latch the parity bit.
  - STOP: on the edge, check stop=1 and odd parity over data plus parity bit. If both pass, assert internal `byte_valid` for one cycle; otherwise pulse `frame_error` and discard the byte. Return to IDLE in either case.
- Timeout: the counter resets on every edge and is held at 0 in IDLE. Reaching `TIMEOUT_CYCLES` in a non-IDLE state forces IDLE and pulses `frame_error`.
- Code decoder, applied to each valid byte, using flags `ext_pending` and `break_pending`:
  - 0xE0: set `ext_pending`.
  - 0xF0: set `break_pending`.
  - Other byte with `ext_pending` set: ignore it (extended keys are never letters) and clear both flags.
  - Other byte with `break_pending` set: if its ASCII equals `user_input`, set `user_input` to 0x00. Clear `break_pending`. No strobe.
  - Other byte, make code:
    - Letter whose ASCII differs from `user_input`: set `user_input` to that ASCII and pulse `key_strobe`.
    - Same letter (typematic repeat): no change, no strobe.
    - Non-letter: no change.
- `frame_error` clears both decoder flags. `user_input` is kept.
- Letter map (set 2 → ASCII):
  - A 1C, B 32, C 21, D 23, E 24, F 2B, G 34
  - H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31
  - O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C
  - V 2A, W 1D, X 22, Y 35, Z 1A
  - Any other code maps to 0x00 (non-letter).

## Timing
- Reset values: `user_input`=0x00, `key_strobe`=0, `frame_error`=0, FSM IDLE, both flags clear, timeout counter 0, synchronizers 1.
- Reset mid-frame aborts the frame with no `frame_error`. The next frame needs a fresh start bit.
- Latency, pins to edge detection: 2 cycles of synchronizer.
- `byte_valid` asserts in the cycle after the stop-bit edge cycle.
- `user_input` and `key_strobe` update on the clock edge after `byte_valid`.
- `frame_error` asserts in the cycle after the failing edge or the timeout count.
- `user_input` is a registered output and holds steady between valid bytes.
- `key_strobe` and `frame_error` are never asserted in the same cycle.

## Structure
- Shared package `flippy_pkg`:
  - FSM state encoding (2 bits).
  - Constants `PS2_EXT`=8'hE0 and `PS2_BREAK`=8'hF0.
  - ASCII bounds `ASCII_A`=8'h41 and `ASCII_Z`=8'h5A, also used by Column.
- Sub-module `ps2_scan_to_ascii`: combinational 8→8 lookup implementing the letter map.
- Top level contains the synchronizers, frame FSM, timeout counter and decoder.

## Test plan
- Valid frame 0x1C → `user_input`=0x41 and a single-cycle `key_strobe`. Then 0x1C again (typematic repeat) → no strobe, stays 0x41.
- 0x1C, then F0 1C → `user_input` returns to 0x00, with no strobe on release.
- 0x1C, then 0x32 → 0x42 with a strobe. Then F0 1C → stays 0x42. Then F0 32 → 0x00.
- 0x1C frame sent with even parity → one `frame_error` pulse, `user_input` stays 0x00. Next good 0x2C → 0x54.
- E0 75, then E0 F0 75 → no output change. Then 0x1B → 0x53.
- Start bit plus 4 data bits, then idle for more than `TIMEOUT_CYCLES` → `frame_error`. Then a full 0x1A frame → 0x5A.
- Assert `reset_signal` mid-frame, then send a full 0x15 frame → 0x51 and no `frame_error`.

Source files
------------

// File: rtl/flippy_pkg.sv
// Shared definitions for the falling-letter game: PS/2 frame states, scan-code
// prefixes and the ASCII letter range the columns compare against.
package flippy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_Z = 8'h5A;

    function automatic logic is_letter(input logic [7:0] ascii);
        return (ascii >= ASCII_A) && (ascii <= ASCII_Z);
    endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Scan code set 2 make code to uppercase ASCII; anything that is not a letter
// key maps to 0x00.
module ps2_scan_to_ascii (
    input  logic [7:0] scan_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        ascii_o = 8'h00;
        case (scan_i)
            8'h1C: ascii_o = 8'h41; // A
            8'h32: ascii_o = 8'h42;
            8'h21: ascii_o = 8'h43;
            8'h23: ascii_o = 8'h44;
            8'h24: ascii_o = 8'h45;
            8'h2B: ascii_o = 8'h46;
            8'h34: ascii_o = 8'h47;
            8'h33: ascii_o = 8'h48;
            8'h43: ascii_o = 8'h49;
            8'h3B: ascii_o = 8'h4A;
            8'h42: ascii_o = 8'h4B;
            8'h4B: ascii_o = 8'h4C;
            8'h3A: ascii_o = 8'h4D;
            8'h31: ascii_o = 8'h4E;
            8'h44: ascii_o = 8'h4F;
            8'h4D: ascii_o = 8'h50;
            8'h15: ascii_o = 8'h51;
            8'h2D: ascii_o = 8'h52;
            8'h1B: ascii_o = 8'h53;
            8'h2C: ascii_o = 8'h54;
            8'h3C: ascii_o = 8'h55;
            8'h2A: ascii_o = 8'h56;
            8'h1D: ascii_o = 8'h57;
            8'h22: ascii_o = 8'h58;
            8'h35: ascii_o = 8'h59;
            8'h1A: ascii_o = 8'h5A; // Z
            default: ascii_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_letter_input.sv
// PS/2 keyboard receiver: synchronizes the pins, deframes bytes, and tracks
// make/break codes to present the currently held letter as ASCII.
module ps2_letter_input
    import flippy_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset_signal,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] user_input,
    output logic       key_strobe,
    output logic       frame_error,
    output logic [1:0] dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic       clk_s1_q, clk_s2_q, clk_prev_q;
    logic       dat_s1_q, dat_s2_q;
    logic       clk_fall;

    ps2_state_e state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       parity_q;
    logic [TW-1:0] tmo_q;

    // byte_valid_q is a one-cycle strobe qualifying byte_q; the decoder has no
    // way to stall the receiver, so every strobed byte is consumed that cycle.
    logic       byte_valid_q;
    logic [7:0] byte_q;
    logic       frame_error_q;

    logic [7:0] user_input_q;
    logic       key_strobe_q;
    logic       ext_pending_q, break_pending_q;
    logic [7:0] ascii;

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_s2_q;

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            parity_q      <= 1'b0;
            tmo_q         <= '0;
            byte_valid_q  <= 1'b0;
            byte_q        <= 8'h00;
            frame_error_q <= 1'b0;
        end else begin
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;

            if (state_q == ST_IDLE || clk_fall)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + TW'(1);

            case (state_q)
                ST_IDLE: begin
                    if (clk_fall && !dat_s2_q) begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (clk_fall) begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7)
                            state_q <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (clk_fall) begin
                        parity_q <= dat_s2_q;
                        state_q  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (clk_fall) begin
                        if (dat_s2_q && (^{shift_q, parity_q})) begin
                            byte_valid_q <= 1'b1;
                            byte_q       <= shift_q;
                        end else begin
                            frame_error_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A stalled frame overrides whatever the case above decided.
            if (state_q != ST_IDLE && !clk_fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_q       <= ST_IDLE;
                frame_error_q <= 1'b1;
            end
        end
    end

    ps2_scan_to_ascii u_lookup (
        .scan_i  (byte_q),
        .ascii_o (ascii)
    );

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            user_input_q    <= 8'h00;
            key_strobe_q    <= 1'b0;
            ext_pending_q   <= 1'b0;
            break_pending_q <= 1'b0;
        end else begin
            key_strobe_q <= 1'b0;
            if (frame_error_q) begin
                ext_pending_q   <= 1'b0;
                break_pending_q <= 1'b0;
            end else if (byte_valid_q) begin
                if (byte_q == PS2_EXT) begin
                    ext_pending_q <= 1'b1;
                end else if (byte_q == PS2_BREAK) begin
                    break_pending_q <= 1'b1;
                end else if (ext_pending_q) begin
                    ext_pending_q   <= 1'b0;
                    break_pending_q <= 1'b0;
                end else if (break_pending_q) begin
                    if (is_letter(ascii) && ascii == user_input_q)
                        user_input_q <= 8'h00;
                    break_pending_q <= 1'b0;
                end else if (is_letter(ascii) && ascii != user_input_q) begin
                    user_input_q <= ascii;
                    key_strobe_q <= 1'b1;
                end
            end
        end
    end

    assign user_input  = user_input_q;
    assign key_strobe  = key_strobe_q;
    assign frame_error = frame_error_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_letter_input.sv
// Directed bench for ps2_letter_input: a PS/2 frame driver feeds scan codes,
// expected strobe/error events go to a queue that a monitor drains.
module tb_ps2_letter_input;

    localparam int TMO  = 200;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk, ps2_data;
    logic [7:0] user_input;
    logic       key_strobe, frame_error;
    logic [1:0] dbg_state;

    // {is_error, ascii}: strobe events carry the new letter, errors carry 0
    logic [8:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    ps2_letter_input #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock        (clk),
        .reset_signal (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .user_input   (user_input),
        .key_strobe   (key_strobe),
        .frame_error  (frame_error),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Monitor: every strobe or error must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (key_strobe || frame_error)) begin
            logic [8:0] got;
            got = {frame_error, (frame_error ? 8'h00 : user_input)};
            n_cmp++;
            if (key_strobe && frame_error) begin
                n_bad++;
                $display("FAIL event_overlap: strobe and error in same cycle");
            end else if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL event_unexpected: got err=%0b val=0x%02h, none queued", got[8], got[7:0]);
            end else begin
                logic [8:0] want;
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL event: got err=%0b val=0x%02h expected err=%0b val=0x%02h",
                             got[8], got[7:0], want[8], want[7:0]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            idle(HALF);
            ps2_clk = 1'b0;
            idle(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_parity);
        logic [10:0] frame;
        frame = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
        send_bits(frame, 11);
        ps2_data = 1'b1;
        idle(2 * HALF);
    endtask

    task automatic expect_key(input logic [7:0] ascii);
        exp_q.push_back({1'b0, ascii});
    endtask

    task automatic expect_err();
        exp_q.push_back(9'h100);
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        idle(4);
        check("reset_user_input", user_input, 8'h00);
        check("reset_key_strobe", {7'd0, key_strobe}, 8'h00);
        check("reset_frame_error", {7'd0, frame_error}, 8'h00);
        check("reset_state", {6'd0, dbg_state}, 8'h00);
        rst = 1'b0;
        idle(4);

        // Press A, then typematic repeat
        expect_key(8'h41);
        send_byte(8'h1C, 1'b0);
        check("press_a", user_input, 8'h41);
        send_byte(8'h1C, 1'b0);
        check("repeat_a", user_input, 8'h41);

        // Release A
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check("release_a", user_input, 8'h00);

        // A then B, release of the stale A leaves B held
        expect_key(8'h41);
        send_byte(8'h1C, 1'b0);
        expect_key(8'h42);
        send_byte(8'h32, 1'b0);
        check("press_b", user_input, 8'h42);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check("release_stale_a", user_input, 8'h42);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h32, 1'b0);
        check("release_b", user_input, 8'h00);

        // Bad parity frame is dropped, next good one decodes
        expect_err();
        send_byte(8'h1C, 1'b1);
        check("bad_parity_hold", user_input, 8'h00);
        expect_key(8'h54);
        send_byte(8'h2C, 1'b0);
        check("press_t", user_input, 8'h54);

        // Extended make and break are ignored entirely
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("ext_make", user_input, 8'h54);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("ext_break", user_input, 8'h54);
        expect_key(8'h53);
        send_byte(8'h1B, 1'b0);
        check("press_s", user_input, 8'h53);

        // Truncated frame times out
        expect_err();
        send_bits(11'b000_0000_1010, 5);
        ps2_data = 1'b1;
        idle(TMO + 40);
        check("timeout_state", {6'd0, dbg_state}, 8'h00);
        check("timeout_hold", user_input, 8'h53);
        expect_key(8'h5A);
        send_byte(8'h1A, 1'b0);
        check("press_z", user_input, 8'h5A);

        // Reset mid-frame aborts silently
        send_bits(11'b000_0000_0110, 4);
        ps2_data = 1'b1;
        rst = 1'b1;
        idle(3);
        check("midreset_user_input", user_input, 8'h00);
        rst = 1'b0;
        idle(4);
        expect_key(8'h51);
        send_byte(8'h15, 1'b0);
        check("press_q", user_input, 8'h51);

        idle(20);
        check("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
